// File: rtl/fifo_rd_drain.sv
// Read-domain drain for the async FIFO: pops one word at a time, presents it to a
// busy-signalling serial consumer, retries on acknowledge timeout and counts delivered words.
module fifo_rd_drain #(
   parameter int DATA_WIDTH  = 8,
   parameter int ACK_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  EMPTY,
   input  logic [DATA_WIDTH-1:0] RD_DATA,
   output logic                  R_INC,
   input  logic                  BUSY,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic                  OUT_VALID,
   output logic                  ACK_ERR,
   output logic [CNT_WIDTH-1:0]  WORD_CNT
);

   localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESENT   = 2'd1,
      WAIT_ACK  = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    r_inc_q, r_inc_d;
   logic                    out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    ack_err_q, ack_err_d;
   logic [CNT_WIDTH-1:0]    word_cnt_q, word_cnt_d;
   logic [7:0]              tmo_q, tmo_d;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         r_inc_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ack_err_q   <= 1'b0;
         word_cnt_q  <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         r_inc_q     <= r_inc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ack_err_q   <= ack_err_d;
         word_cnt_q  <= word_cnt_d;
         tmo_q       <= tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      r_inc_d     = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      ack_err_d   = ack_err_q;
      word_cnt_d  = word_cnt_q;
      tmo_d       = tmo_q;
      case (state_q)
         IDLE: begin
            if (EN && !EMPTY) begin
               out_data_d  = RD_DATA;
               r_inc_d     = 1'b1;
               out_valid_d = 1'b1;
               state_d     = PRESENT;
            end
         end
         PRESENT: begin
            tmo_d   = '0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            // BUSY wins over expiry; a retry re-presents the held word without popping.
            if (BUSY) begin
               state_d = WAIT_DONE;
            end else if (tmo_q == TMO_LAST) begin
               ack_err_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = PRESENT;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         WAIT_DONE: begin
            if (!BUSY) begin
               word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign R_INC     = r_inc_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign ACK_ERR   = ack_err_q;
   assign WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: vector table, directed corner sequences and a randomized
// stream checked against a transaction-level FIFO/consumer model.
module tb_fifo_rd_drain;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EN = 1'b1;
   logic       EMPTY = 1'b1;
   logic [7:0] RD_DATA = 8'h00;
   logic       BUSY = 1'b0;
   logic       R_INC;
   logic [7:0] OUT_DATA;
   logic       OUT_VALID;
   logic       ACK_ERR;
   logic [3:0] WORD_CNT;

   fifo_rd_drain #(.DATA_WIDTH(8), .ACK_TIMEOUT(16), .CNT_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .EMPTY(EMPTY), .RD_DATA(RD_DATA),
      .R_INC(R_INC), .BUSY(BUSY), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
      .ACK_ERR(ACK_ERR), .WORD_CNT(WORD_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst, en, empty;
      logic [7:0] data;
      logic       busy;
      logic       r_inc, ov;
      logic [7:0] od;
      logic       err;
      logic [3:0] cnt;
   } vec_t;

   int         nvec = 0;
   int         nerr = 0;
   logic [7:0] fq[$];
   logic [7:0] last_word = 8'h00;
   int         done = 0;
   int         pops = 0;
   int         c_delay = -1;
   int         c_hold = 0;
   bit         auto_cons = 1'b0;
   bit         cons_rand = 1'b0;
   bit         chk_cnt = 1'b0;
   bit         chk_err = 1'b0;

   function automatic vec_t v(logic rst, logic en, logic empty, logic [7:0] data, logic busy,
                              logic r_inc, logic ov, logic [7:0] od, logic err, logic [3:0] cnt);
      vec_t r;
      r.rst = rst; r.en = en; r.empty = empty; r.data = data; r.busy = busy;
      r.r_inc = r_inc; r.ov = ov; r.od = od; r.err = err; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_fifo();
      EMPTY   = (fq.size() == 0);
      RD_DATA = (fq.size() != 0) ? fq[0] : 8'h00;
   endtask

   // One clock: observe outputs, update the FIFO/consumer model, drive the next inputs.
   task automatic tick();
      logic       pe;
      logic [7:0] exp;
      pe = EMPTY;
      @(posedge CLK);
      #1;
      if (R_INC) begin
         chk("rinc_not_empty", pe, 1'b0);
         chk("rinc_with_valid", OUT_VALID, 1'b1);
         if (fq.size() != 0) begin
            exp = fq.pop_front();
            chk("pop_data", OUT_DATA, exp);
            last_word = exp;
         end else begin
            nvec++;
            nerr++;
            $display("FAIL pop_data: R_INC with no word queued, OUT_DATA=%0h", OUT_DATA);
         end
         pops++;
      end else if (OUT_VALID) begin
         chk("retry_data", OUT_DATA, last_word);
      end
      if (chk_cnt) begin
         chk("word_cnt", WORD_CNT, done % 16);
         chk("one_outstanding", (pops - done) <= 1, 1'b1);
      end
      if (chk_err) chk("ack_err_clear", ACK_ERR, 1'b0);
      if (auto_cons) begin
         if (BUSY) begin
            c_hold--;
            if (c_hold == 0) begin
               BUSY = 1'b0;
               done++;
            end
         end else begin
            if (c_delay < 0 && OUT_VALID) c_delay = cons_rand ? int'($urandom_range(5, 1)) : 1;
            if (c_delay == 0) begin
               BUSY    = 1'b1;
               c_hold  = cons_rand ? int'($urandom_range(6, 1)) : 1;
               c_delay = -1;
            end else if (c_delay > 0) begin
               c_delay--;
            end
         end
      end
      drive_fifo();
   endtask

   task automatic do_reset();
      RST = 1'b1;
      auto_cons = 1'b0; cons_rand = 1'b0; chk_cnt = 1'b0; chk_err = 1'b0;
      BUSY = 1'b0; c_delay = -1; c_hold = 0;
      fq.delete();
      drive_fifo();
      tick();
      tick();
      RST = 1'b0;
      done = 0;
      pops = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, %0d vectors applied", nvec);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[16];
      int   ov_n, last_ov, rinc_n, pushed;
      const int TOT = 120;

      // Reset, two-word handshake, empty/EN blocking, reset during PRESENT.
      tbl[0]  = v(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      tbl[1]  = v(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      tbl[2]  = v(1'b0, 1'b1, 1'b0, 8'hA5, 1'b0,  1'b1, 1'b1, 8'hA5, 1'b0, 4'd0);
      tbl[3]  = v(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0,  1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
      tbl[4]  = v(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1,  1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
      tbl[5]  = v(1'b0, 1'b1, 1'b0, 8'h3C, 1'b1,  1'b0, 1'b0, 8'hA5, 1'b0, 4'd0);
      tbl[6]  = v(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0,  1'b0, 1'b0, 8'hA5, 1'b0, 4'd1);
      tbl[7]  = v(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0,  1'b1, 1'b1, 8'h3C, 1'b0, 4'd1);
      tbl[8]  = v(1'b0, 1'b0, 1'b1, 8'h00, 1'b1,  1'b0, 1'b0, 8'h3C, 1'b0, 4'd1);
      tbl[9]  = v(1'b0, 1'b0, 1'b1, 8'h00, 1'b1,  1'b0, 1'b0, 8'h3C, 1'b0, 4'd1);
      tbl[10] = v(1'b0, 1'b0, 1'b1, 8'h00, 1'b0,  1'b0, 1'b0, 8'h3C, 1'b0, 4'd2);
      tbl[11] = v(1'b0, 1'b1, 1'b1, 8'h00, 1'b0,  1'b0, 1'b0, 8'h3C, 1'b0, 4'd2);
      tbl[12] = v(1'b0, 1'b0, 1'b0, 8'h55, 1'b0,  1'b0, 1'b0, 8'h3C, 1'b0, 4'd2);
      tbl[13] = v(1'b0, 1'b1, 1'b0, 8'h55, 1'b0,  1'b1, 1'b1, 8'h55, 1'b0, 4'd2);
      tbl[14] = v(1'b1, 1'b1, 1'b0, 8'h66, 1'b1,  1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
      tbl[15] = v(1'b0, 1'b1, 1'b1, 8'h00, 1'b0,  1'b0, 1'b0, 8'h00, 1'b0, 4'd0);

      for (int i = 0; i < 16; i++) begin
         RST = tbl[i].rst; EN = tbl[i].en; EMPTY = tbl[i].empty;
         RD_DATA = tbl[i].data; BUSY = tbl[i].busy;
         @(posedge CLK);
         #1;
         chk($sformatf("tbl%0d_r_inc", i), R_INC, tbl[i].r_inc);
         chk($sformatf("tbl%0d_out_valid", i), OUT_VALID, tbl[i].ov);
         chk($sformatf("tbl%0d_out_data", i), OUT_DATA, tbl[i].od);
         chk($sformatf("tbl%0d_ack_err", i), ACK_ERR, tbl[i].err);
         chk($sformatf("tbl%0d_word_cnt", i), WORD_CNT, tbl[i].cnt);
      end

      // EN gating: nothing popped while disabled, EN drop in WAIT_DONE finishes one word only.
      EN = 1'b0;
      do_reset();
      fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
      drive_fifo();
      auto_cons = 1'b1; chk_cnt = 1'b1; chk_err = 1'b1;
      rinc_n = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (R_INC) rinc_n++;
      end
      chk("en0_no_pop", rinc_n, 0);
      EN = 1'b1;
      for (int k = 0; k < 40 && !BUSY; k++) tick();
      chk("en_busy_seen", BUSY, 1'b1);
      EN = 1'b0;
      for (int k = 0; k < 40; k++) tick();
      chk("en_drop_cnt", WORD_CNT, 4'd1);
      chk("en_drop_pops", pops, 1);
      chk("en_drop_left", fq.size(), 2);
      EN = 1'b1;
      for (int k = 0; k < 100 && done != 3; k++) tick();
      tick();
      chk("en_drain_cnt", WORD_CNT, 4'd3);
      chk("en_drain_left", fq.size(), 0);

      // Acknowledge timeout: retries every ACK_TIMEOUT+1 cycles with a single pop.
      do_reset();
      fq.push_back(8'h77);
      drive_fifo();
      EN = 1'b1;
      ov_n = 0; last_ov = 0; rinc_n = 0;
      for (int t = 1; t <= 60; t++) begin
         tick();
         if (R_INC) rinc_n++;
         if (OUT_VALID) begin
            if (ov_n > 0) chk("retry_period", t - last_ov, 17);
            last_ov = t;
            ov_n++;
            chk("retry_out_data", OUT_DATA, 8'h77);
         end
         chk("ack_err_sticky", ACK_ERR, ov_n >= 2);
      end
      chk("tmo_single_pop", rinc_n, 1);
      chk("tmo_valid_pulses", ov_n, 4);
      auto_cons = 1'b1;
      for (int k = 0; k < 80 && done != 1; k++) tick();
      tick();
      chk("tmo_word_cnt", WORD_CNT, 4'd1);
      chk("tmo_ack_err_kept", ACK_ERR, 1'b1);

      // Reset during WAIT_DONE discards the in-flight word.
      do_reset();
      fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
      drive_fifo();
      EN = 1'b1;
      for (int k = 0; k < 10 && !R_INC; k++) tick();
      chk("rst_fetch", R_INC, 1'b1);
      tick();
      BUSY = 1'b1;
      tick();
      tick();
      RST = 1'b1;
      tick();
      chk("rst_r_inc", R_INC, 1'b0);
      chk("rst_out_valid", OUT_VALID, 1'b0);
      chk("rst_out_data", OUT_DATA, 8'h00);
      chk("rst_word_cnt", WORD_CNT, 4'd0);
      chk("rst_ack_err", ACK_ERR, 1'b0);
      RST = 1'b0; BUSY = 1'b0; done = 0; pops = 0; c_delay = -1;
      auto_cons = 1'b1; chk_cnt = 1'b1; chk_err = 1'b1;
      for (int k = 0; k < 100 && done != 2; k++) tick();
      tick();
      chk("rst_after_cnt", WORD_CNT, 4'd2);
      chk("rst_after_left", fq.size(), 0);

      // 17-word stream at full rate: counter wraps through 0.
      do_reset();
      for (int i = 0; i < 17; i++) fq.push_back(8'(i * 13 + 5));
      drive_fifo();
      EN = 1'b1;
      auto_cons = 1'b1; chk_cnt = 1'b1; chk_err = 1'b1;
      for (int k = 0; k < 300 && done != 17; k++) tick();
      tick();
      chk("wrap_done", done, 17);
      chk("wrap_word_cnt", WORD_CNT, 4'd1);

      // Randomized traffic, EN toggling and consumer timing.
      do_reset();
      auto_cons = 1'b1; cons_rand = 1'b1; chk_cnt = 1'b1; chk_err = 1'b1;
      pushed = 0;
      for (int k = 0; k < 6000 && !(pushed == TOT && done == TOT); k++) begin
         if (pushed < TOT && $urandom_range(3, 0) == 0) begin
            fq.push_back(8'($urandom));
            pushed++;
            drive_fifo();
         end
         EN = ($urandom_range(9, 0) != 0);
         tick();
      end
      chk("rand_done", done, TOT);
      chk("rand_pops", pops, TOT);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer of the asynchronous FIFO, clocked in the read domain.
- Watches EMPTY and RD_DATA, pops one word at a time with a single-cycle R_INC pulse, and presents each word to a busy-signalling serial consumer (UART transmitter class) as a one-cycle OUT_VALID pulse.
- Holds off the next pop until the consumer has raised and then dropped BUSY.
- Adds an acknowledge timeout with retry and a delivered-word counter for system status.

Parameters:
- DATA_WIDTH, 8: width of RD_DATA and OUT_DATA.
- ACK_TIMEOUT, 16: cycles to wait in WAIT_ACK for BUSY to rise before re-presenting the word; legal range 2..255.
- CNT_WIDTH, 8: width of the delivered-word counter WORD_CNT.

Ports:
- CLK, input, 1: read-domain clock; all logic is rising-edge.
- RST, input, 1: synchronous, active-high reset.
- EN, input, 1: drain enable; gates only new fetches.
- EMPTY, input, 1: FIFO empty flag from the read domain.
- RD_DATA, input, DATA_WIDTH: FIFO show-ahead read data at the current read address.
- R_INC, output, 1: FIFO pop strobe, one cycle per word, registered.
- BUSY, input, 1: consumer busy; high while the word is being serialised.
- OUT_DATA, output, DATA_WIDTH: registered word for the consumer; held stable from the fetch until the next fetch.
- OUT_VALID, output, 1: one-cycle data-valid pulse to the consumer.
- ACK_ERR, output, 1: sticky flag, set on any ACK_TIMEOUT expiry.
- WORD_CNT, output, CNT_WIDTH: words completed (BUSY fall observed); wraps modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset (already decided): one clock, CLK. RST is synchronous and active-high.
- Reset values: state IDLE, R_INC=0, OUT_VALID=0, OUT_DATA=0, ACK_ERR=0, WORD_CNT=0, timeout counter=0.
- Reset mid-operation: applies at the next edge regardless of state. A word already popped but not yet delivered is discarded and not counted.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, PRESENT, WAIT_ACK, WAIT_DONE.
- IDLE:
  - On an edge with EN=1 and EMPTY=0: OUT_DATA<=RD_DATA, R_INC<=1, OUT_VALID<=1, state<=PRESENT.
  - Otherwise hold; R_INC and OUT_VALID stay 0.
- PRESENT (exactly 1 cycle, R_INC=1 and OUT_VALID=1 visible):
  - At the edge: R_INC<=0, OUT_VALID<=0, timeout counter<=0, state<=WAIT_ACK.
  - The FIFO pops at this edge. EMPTY is not sampled in this state.
- WAIT_ACK:
  - BUSY=1 -> state<=WAIT_DONE.
  - Else if timeout counter = ACK_TIMEOUT-1 -> ACK_ERR<=1, OUT_VALID<=1, state<=PRESENT with R_INC held at 0 (retry re-presents the same OUT_DATA and never pops again).
  - Else increment the timeout counter.
  - Retries repeat without limit.
- WAIT_DONE:
  - BUSY=0 -> WORD_CNT<=WORD_CNT+1, state<=IDLE.
  - Else hold. No timeout on BUSY high.
- Throughput:
  - Minimum 4 cycles per word: fetch edge, PRESENT, at least 1 cycle of WAIT_ACK, at least 1 cycle of WAIT_DONE.
  - Back-to-back fetch: the IDLE entry cycle samples EMPTY, which is valid because the read pointer was updated at least 2 edges earlier.
- EN=0 while not in IDLE: the current word completes normally; only the next fetch is blocked.
- EMPTY rising while not in IDLE: ignored until IDLE is re-entered.
- BUSY already high when entering WAIT_ACK: counts as an acknowledge immediately.
- WORD_CNT wraps from 2^CNT_WIDTH-1 to 0 without a flag.
- ACK_ERR clears only on RST.
- R_INC is never asserted when EMPTY was 1 at the fetch edge (no underflow).
- Never more than one unacknowledged word is outstanding.

Test Plan:
1. RST=1 for 2 cycles with EMPTY=0, EN=1 -> R_INC=0, OUT_VALID=0, WORD_CNT=0, ACK_ERR=0; first R_INC appears 1 cycle after RST falls.
2. FIFO preloaded with 0xA5, 0x3C; consumer raises BUSY 1 cycle after OUT_VALID and holds it 10 cycles -> exactly two R_INC pulses; OUT_DATA 0xA5 then 0x3C, each with one OUT_VALID pulse; WORD_CNT=2; FIFO EMPTY=1 at the end.
3. EN=0 with 3 words queued -> no R_INC for 50 cycles. EN=1 -> words drain in order. EN dropped during WAIT_DONE of word 1 -> word 1 completes (WORD_CNT=1) and no further pops occur.
4. BUSY tied 0, ACK_TIMEOUT=16, word 0x77 -> one R_INC only; OUT_VALID re-pulses every 17 cycles with OUT_DATA=0x77; ACK_ERR=1 after the first expiry. Releasing BUSY handshake -> WORD_CNT=1, ACK_ERR stays 1.
5. RST asserted in WAIT_DONE with 2 words still queued -> IDLE next edge, WORD_CNT=0; the remaining 2 words delivered afterwards; the in-flight word is lost.
6. CNT_WIDTH=4, 17 words streamed -> WORD_CNT sequence 1..15, 0, 1; no ACK_ERR; no R_INC asserted while EMPTY=1.
